// File: rtl/sha256_msg_padder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_pkg                                                 |
// | Purpose : Shared types, constants and helpers for the SHA-256        |
// |           message padder (state encoding, pad word, block size).     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package sha256_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_PAD    = 3'd2,
      ST_ZERO   = 3'd3,
      ST_LEN_HI = 3'd4,
      ST_LEN_LO = 3'd5,
      ST_DRAIN  = 3'd6
   } pad_state_t;

   localparam logic [31:0] PAD_WORD        = 32'h8000_0000;
   localparam int          WORDS_PER_BLOCK = 16;

   // Padded length in words: message + pad word + two length words,
   // rounded up to a whole number of 16-word blocks.
   function automatic logic [32:0] padded_words(input logic [31:0] num_words);
      logic [32:0] n;
      n = {1'b0, num_words} + 33'd3 + 33'(WORDS_PER_BLOCK - 1);
      return {n[32:4], 4'b0000};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_msg_padder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_msg_padder_if                                       |
// | Purpose : Valid/ready word stream carrying the padded message and    |
// |           its block / message boundary flags.                        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface sha256_msg_padder_if #(
   parameter int ADDR_W = 16
) ();
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic              out_blk_last;
   logic              out_msg_last;
   logic [ADDR_W-1:0] out_blk_idx;

   modport master (
      output out_valid, out_data, out_blk_last, out_msg_last, out_blk_idx,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_blk_last, out_msg_last, out_blk_idx,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/sha256_msg_padder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_word_fifo                                           |
// | Purpose : Small synchronous FIFO for padded words plus their flags.  |
// |           Push while full is accepted only together with a pop.      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sha256_word_fifo #(
   parameter  int DEPTH = 2,
   parameter  int WIDTH = 34,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   input  wire logic             push,
   input  wire logic [WIDTH-1:0] push_data,
   input  wire logic             pop,
   output logic      [WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty,
   output logic      [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // Pointer, storage and occupancy update for one push and/or pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // FIFO state registers; reset empties the buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule
`default_nettype wire

// File: rtl/sha256_msg_padder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sha256_msg_padder                                          |
// | Purpose : Reads a message from word memory, appends SHA-256 padding  |
// |           (0x80000000, zeros, 64-bit bit length) and streams the     |
// |           result with block / message boundary flags.                |
// | Options : SHA256_PAD_BYTE_SWAP_EN - byte-reverse memory words        |
// |           (little-endian image); padding/length never swapped.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sha256_msg_padder
   import sha256_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int BUF_DEPTH = 2
) (
   input  wire logic              clk,
   input  wire logic              reset_n,
   input  wire logic              start,
   input  wire logic [ADDR_W-1:0] message_addr,
   input  wire logic [ADDR_W-1:0] num_words,
   output logic                   busy,
   output logic                   mem_clk,
   output logic                   mem_we,
   output logic      [ADDR_W-1:0] mem_addr,
   input  wire logic [31:0]       mem_read_data,
   sha256_msg_padder_if.master    out_if
);

   localparam int CNT_W  = ADDR_W + 1;
   localparam int FIFO_W = 34;
   localparam int FCNT_W = $clog2(BUF_DEPTH + 1);

   pad_state_t        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] nwords_q, nwords_d;
   logic [ADDR_W-1:0] blk_idx_q, blk_idx_d;
   logic [CNT_W-1:0]  read_cnt_q, read_cnt_d;
   logic [CNT_W-1:0]  push_idx_q, push_idx_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic              inflight_q, inflight_d;

   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_empty, fifo_full;
   logic              fifo_push, fifo_pop;
   logic [FIFO_W-1:0] fifo_din, fifo_dout;
   logic [31:0]       push_word, mem_word;
   logic [63:0]       bit_len;
   logic              room_rd, room_pad;

`ifdef SHA256_PAD_BYTE_SWAP_EN
   assign mem_word = {mem_read_data[7:0], mem_read_data[15:8],
                      mem_read_data[23:16], mem_read_data[31:24]};
`else
   assign mem_word = mem_read_data;
`endif

   assign bit_len = {{(64 - ADDR_W - 5){1'b0}}, nwords_q, 5'b00000};

   // Sequencing: read issue, ordered buffer pushes and block index tracking.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      nwords_d   = nwords_q;
      read_cnt_d = read_cnt_q;
      push_idx_d = push_idx_q;
      total_d    = total_q;
      blk_idx_d  = blk_idx_q;
      inflight_d = 1'b0;
      fifo_push  = 1'b0;
      push_word  = '0;
      fifo_pop   = !fifo_empty && out_if.out_ready;
      // A word leaving this cycle frees a slot for the next issue/push.
      room_rd    = ((int'(fifo_count) + int'(inflight_q)) < BUF_DEPTH) || fifo_pop;
      // Padding waits until the last memory word has landed.
      room_pad   = !inflight_q && (!fifo_full || fifo_pop);

      if (inflight_q) begin
         fifo_push = 1'b1;
         push_word = mem_word;
      end

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d     = message_addr;
               nwords_d   = num_words;
               read_cnt_d = '0;
               push_idx_d = '0;
               blk_idx_d  = '0;
               total_d    = CNT_W'(padded_words(32'(num_words)));
               state_d    = (num_words == '0) ? ST_PAD : ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (room_rd) begin
               inflight_d = 1'b1;
               read_cnt_d = read_cnt_q + 1'b1;
               if (read_cnt_q + 1'b1 == {1'b0, nwords_q}) state_d = ST_PAD;
            end
         end
         ST_PAD: begin
            if (room_pad) begin
               fifo_push = 1'b1;
               push_word = PAD_WORD;
               state_d   = (push_idx_q + 1'b1 == total_q - 2'd2) ? ST_LEN_HI : ST_ZERO;
            end
         end
         ST_ZERO: begin
            if (room_pad) begin
               fifo_push = 1'b1;
               if (push_idx_q + 1'b1 == total_q - 2'd2) state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (room_pad) begin
               fifo_push = 1'b1;
               push_word = bit_len[63:32];
               state_d   = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (room_pad) begin
               fifo_push = 1'b1;
               push_word = bit_len[31:0];
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_pop && fifo_dout[33]) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (fifo_push) push_idx_d = push_idx_q + 1'b1;
      if (fifo_pop && fifo_dout[32]) blk_idx_d = blk_idx_q + 1'b1;
   end

   // Control registers; reset discards any read still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         base_q     <= '0;
         nwords_q   <= '0;
         blk_idx_q  <= '0;
         read_cnt_q <= '0;
         push_idx_q <= '0;
         total_q    <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         nwords_q   <= nwords_d;
         blk_idx_q  <= blk_idx_d;
         read_cnt_q <= read_cnt_d;
         push_idx_q <= push_idx_d;
         total_q    <= total_d;
         inflight_q <= inflight_d;
      end
   end

   assign fifo_din = {(push_idx_q == total_q - 1'b1),
                      (push_idx_q[3:0] == 4'(WORDS_PER_BLOCK - 1)),
                      push_word};

   sha256_word_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (fifo_din),
      .pop       (fifo_pop),
      .pop_data  (fifo_dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign out_if.out_valid    = !fifo_empty;
   assign out_if.out_data     = fifo_empty ? '0 : fifo_dout[31:0];
   assign out_if.out_blk_last = !fifo_empty && fifo_dout[32];
   assign out_if.out_msg_last = !fifo_empty && fifo_dout[33];
   assign out_if.out_blk_idx  = blk_idx_q;

   assign busy     = (state_q != ST_IDLE);
   assign mem_clk  = clk;
   assign mem_we   = 1'b0;
   assign mem_addr = base_q + read_cnt_q[ADDR_W-1:0];

endmodule
`default_nettype wire
